// File: rtl/float_pkg.sv
// Single-precision float layout plus shared types for the add/subtract
// normalization stage.
package float_pkg;

   localparam int unsigned EXPONENT_BITS = 8;
   localparam int unsigned FRACTION_BITS = 23;
   localparam int unsigned SIG_BITS      = FRACTION_BITS + 1;

   typedef struct packed {
      logic                     sign;
      logic [EXPONENT_BITS-1:0] exponent;
      logic [FRACTION_BITS-1:0] fraction;
   } float;

   typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} addnorm_state_t;

   function automatic float make_float(input logic                     s,
                                       input logic [EXPONENT_BITS-1:0] e,
                                       input logic [FRACTION_BITS-1:0] f);
      float v;
      v.sign     = s;
      v.exponent = e;
      v.fraction = f;
      return v;
   endfunction

endpackage

// File: rtl/fp_sig_addsub.sv
// Signed-magnitude significand add/subtract: magnitude is one bit wider than
// the significand so a same-sign carry is visible.
module fp_sig_addsub
   import float_pkg::*;
(
   input  logic [SIG_BITS-1:0] sig_b,
   input  logic [SIG_BITS-1:0] sig_s,
   input  logic                sign_b,
   input  logic                sign_s,
   output logic                carry,
   output logic [SIG_BITS:0]   magnitude,
   output logic                sign,
   output logic                zero
);

   always_comb begin
      if (sign_b == sign_s) begin
         magnitude = {1'b0, sig_b} + {1'b0, sig_s};
         sign      = sign_b;
      end else if (sig_b >= sig_s) begin
         magnitude = {1'b0, sig_b - sig_s};
         sign      = sign_b;
      end else begin
         magnitude = {1'b0, sig_s - sig_b};
         sign      = sign_s;
      end
      carry = magnitude[SIG_BITS];
      zero  = (magnitude == '0);
   end

endmodule

// File: rtl/fp_addsub_normalize.sv
// FP adder back end: adds/subtracts aligned significands, normalizes one
// left shift per cycle, and presents a truncated result over valid/ready.
module fp_addsub_normalize
   import float_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic in_valid,
   output logic in_ready,
   input  float bign,
   input  float aligned,
   input  logic small_hidden,
   output logic out_valid,
   input  logic out_ready,
   output float result,
   output logic busy
);

   addnorm_state_t state, state_n;
   logic [SIG_BITS-1:0]      sig, sig_n, sig_s, sig_s_n, sig_shift;
   logic [EXPONENT_BITS-1:0] exp, exp_n, exp_inc, exp_dec;
   logic                     sign_b, sign_b_n, sign_s, sign_s_n, res_sign, res_sign_n;
   float                     result_n;
   logic                     sum_carry, sum_sign, sum_zero;
   logic [SIG_BITS:0]        magnitude;
   logic                     unused_bits;

   // the aligned exponent equals bign's by construction
   assign unused_bits = ^aligned.exponent;

   fp_sig_addsub u_addsub (
      .sig_b     (sig),
      .sig_s     (sig_s),
      .sign_b    (sign_b),
      .sign_s    (sign_s),
      .carry     (sum_carry),
      .magnitude (magnitude),
      .sign      (sum_sign),
      .zero      (sum_zero)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign exp_inc   = exp + 1'b1;
   assign exp_dec   = exp - 1'b1;
   assign sig_shift = {sig[SIG_BITS-2:0], 1'b0};

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         sig      <= '0;
         sig_s    <= '0;
         exp      <= '0;
         sign_b   <= 1'b0;
         sign_s   <= 1'b0;
         res_sign <= 1'b0;
         result   <= '0;
      end else begin
         state    <= state_n;
         sig      <= sig_n;
         sig_s    <= sig_s_n;
         exp      <= exp_n;
         sign_b   <= sign_b_n;
         sign_s   <= sign_s_n;
         res_sign <= res_sign_n;
         result   <= result_n;
      end
   end

   always_comb begin
      state_n    = state;
      sig_n      = sig;
      sig_s_n    = sig_s;
      exp_n      = exp;
      sign_b_n   = sign_b;
      sign_s_n   = sign_s;
      res_sign_n = res_sign;
      result_n   = result;
      case (state)
         IDLE: begin
            if (in_valid) begin
               sig_n    = {1'b1, bign.fraction};
               sig_s_n  = {small_hidden, aligned.fraction};
               exp_n    = bign.exponent;
               sign_b_n = bign.sign;
               sign_s_n = aligned.sign;
               state_n  = ADD;
            end
         end
         ADD: begin
            res_sign_n = sum_sign;
            state_n    = DONE;
            if (exp == '1) begin
               result_n = make_float(sign_b, exp, sig[FRACTION_BITS-1:0]);
            end else if (exp == '0) begin
               result_n = make_float(sign_b & sign_s, '0, '0);
            end else if (sum_zero) begin
               result_n = '0;
            end else if (sum_carry) begin
               sig_n = magnitude[SIG_BITS:1];
               exp_n = exp_inc;
               if (exp_inc == '1) result_n = make_float(sum_sign, '1, '0);
               else result_n = make_float(sum_sign, exp_inc, magnitude[FRACTION_BITS:1]);
            end else begin
               sig_n = magnitude[SIG_BITS-1:0];
               if (magnitude[FRACTION_BITS])
                  result_n = make_float(sum_sign, exp, magnitude[FRACTION_BITS-1:0]);
               else
                  state_n = NORM;
            end
         end
         NORM: begin
            // flush once the exponent would hit zero: no denormals are produced
            if (exp <= EXPONENT_BITS'(1)) begin
               result_n = make_float(res_sign, '0, '0);
               state_n  = DONE;
            end else begin
               sig_n = sig_shift;
               exp_n = exp_dec;
               if (sig_shift[FRACTION_BITS]) begin
                  result_n = make_float(res_sign, exp_dec, sig_shift[FRACTION_BITS-1:0]);
                  state_n  = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fp_addsub_normalize.sv
// Scoreboard bench for fp_addsub_normalize: directed float vectors with
// hand-computed results and latencies, checked by an independent monitor.
module tb_fp_addsub_normalize;
   import float_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
   } expect_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   float bign = '0;
   float aligned = '0;
   logic small_hidden = 1'b0;
   logic out_valid;
   logic out_ready = 1'b1;
   float result;
   logic busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   expect_t sb[$];

   fp_addsub_normalize dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .bign         (bign),
      .aligned      (aligned),
      .small_hidden (small_hidden),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .busy         (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] b, input logic [31:0] a, input logic h,
                       input logic [31:0] exp_res, input int exp_lat, input bit track);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_wait: in_ready still low after %0d cycles", n);
         return;
      end
      bign = b;
      aligned = a;
      small_hidden = h;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      if (track) sb.push_back('{exp_res, exp_lat, cyc});
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0 || out_valid) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d results outstanding after %0d cycles", sb.size(), n);
      end
   endtask

   // Monitor: latency counts edges from the accept edge to the first edge
   // that samples out_valid high (the edge after this negedge).
   initial begin
      bit seen = 1'b0;
      expect_t e;
      forever begin
         @(negedge clock);
         if (reset) seen = 1'b0;
         else if (out_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", result);
            end else begin
               e = sb.pop_front();
               check("result", result, e.res);
               check("latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
            end
         end else if (!out_valid) seen = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clock);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_result", result, 32'h0);
      reset = 1'b0;
      @(negedge clock);

      send(32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 2, 1'b1);  drain();  // 1+1
      send(32'h3F800000, 32'hBFE00000, 1'b0, 32'h3E800000, 4, 1'b1);  drain();  // 1-0.75
      send(32'h3F800000, 32'hBF800000, 1'b1, 32'h00000000, 2, 1'b1);  drain();  // cancel
      send(32'h7F800000, 32'h12345678, 1'b0, 32'h7F800000, 2, 1'b1);  drain();  // inf
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 2, 1'b1);  drain();  // overflow
      send(32'h3F800000, 32'hBFC00000, 1'b1, 32'hBF000000, 3, 1'b1);  drain();  // 1-1.5
      send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2, 1'b1);  drain();  // zero exp
      send(32'h00800000, 32'h80C00000, 1'b1, 32'h80000000, 3, 1'b1);  drain();  // flush
      send(32'h3F800000, 32'hBFFFFFFF, 1'b0, 32'h34000000, 25, 1'b1); drain();  // max shifts

      // backpressure: result held, inputs ignored while DONE
      out_ready = 1'b0;
      send(32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 2, 1'b1);
      begin
         int n = 0;
         while (!out_valid && n < 50) begin
            @(negedge clock);
            n++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_result", result, 32'h40000000);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         bign = 32'h40400000;
         aligned = 32'h40400000;
         small_hidden = 1'b1;
         in_valid = 1'b1;
         @(negedge clock);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      drain();

      // reset during the first NORM cycle discards the transaction
      send(32'h3F800000, 32'hBFE00000, 1'b0, 32'h3E800000, 4, 1'b0);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", result, 32'h0);
      send(32'h3F800000, 32'hBFE00000, 1'b0, 32'h3E800000, 4, 1'b1);  drain();

      repeat (3) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp_addsub_normalize.md
Name: fp_addsub_normalize

Overview:
Downstream neighbour of the alignment stage in the multi-cycle FP adder.
- Takes the big operand and the aligned small operand (same exponent), and adds or subtracts the significands by sign.
- Normalizes iteratively, one left shift per cycle, and hands a packed float result to the consumer over a valid/ready handshake.
- Truncates; no rounding.

Parameters:
None. All widths come from float_pkg: EXPONENT_BITS, FRACTION_BITS, and type float {sign, exponent, fraction}.

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
bign  input  float  larger-magnitude operand
aligned  input  float  small operand after alignment (exponent = bign.exponent)
small_hidden  input  1  hidden bit of the aligned significand; 1 only when no shift occurred
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  float  normalized sum
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous; takes effect at the clock edge with reset high.
  - state=IDLE; out_valid=0; result='0; busy=0; in_ready=1.
  - Reset overrides everything, including mid-NORM and a DONE result that has not been consumed; the pending result is discarded.
- States: IDLE, ADD, NORM, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready, register the following, then go to ADD:
  - sig_b = {1, bign.fraction}
  - sig_s = {small_hidden, aligned.fraction}
  - exp = bign.exponent
  - the signs of both operands
- ADD (one cycle). Special cases are checked in this order; the first match wins:
  1. bign.exponent all-ones: result=bign (inf/NaN passthrough) -> DONE.
  2. bign.exponent==0: result={sign_b&sign_s, 0, 0} -> DONE.
  3. Signs equal: sum = sig_b + sig_s, computed FRACTION_BITS+2 wide.
     - If carry: sig = sum>>1, exp+1.
     - If exp+1 is all-ones: result={sign_b, all-ones, 0} (overflow to infinity).
     - Sign = sign_b.
  4. Signs differ: if sig_b >= sig_s, sig = sig_b - sig_s with sign_b; otherwise sig = sig_s - sig_b with sign_s.
     - If sig==0: result = +0 (all zeros) -> DONE.
  - After the add, if sig[FRACTION_BITS]==1 -> DONE; otherwise -> NORM.
- NORM: each cycle shift sig left by 1 and decrement exp.
  - Leave to DONE once sig[FRACTION_BITS]==1.
  - If exp would reach 0 before the hidden bit is set, flush: result = {sign, 0, 0} -> DONE. No denormals are produced.
- DONE: result = {sign, exp, sig[FRACTION_BITS-1:0]}, held stable while out_valid && !out_ready.
  - On out_ready -> IDLE; in_ready rises the next cycle. No same-cycle re-accept.
- Latency, measured from the accept edge to the first cycle with out_valid high:
  - 2 cycles with no normalization shift.
  - 2+k cycles with k shifts; maximum k = FRACTION_BITS, so 25 cycles for single precision.
- Inputs are ignored outside IDLE. result only updates on entry to DONE.
- in_valid without handshake: no state change.

Decomposition:
- float_pkg additions:
  - SIG_BITS = FRACTION_BITS+1
  - typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} addnorm_state_t
- One combinational sub-module, fp_sig_addsub. It computes the signed magnitude add/subtract and outputs:
  - a carry flag
  - the magnitude
  - the result sign
  - a zero flag
- FSM, registers and normalization stay in fp_addsub_normalize.

Test Plan:
- 1.0+1.0: bign=0x3F800000, aligned=0x3F800000, hidden=1 -> result=0x40000000, out_valid exactly 2 cycles after accept.
- 1.0-0.75: bign=0x3F800000, aligned={1,127,0x600000}, hidden=0 -> result=0x3E800000 (0.25) after 2 NORM shifts, latency 4.
- Cancellation: bign=0x3F800000, aligned=0xBF800000, hidden=1 -> result=0x00000000, latency 2. Also bign=0x7F800000 with any aligned -> result=0x7F800000.
- Overflow: bign=0x7F7FFFFF, aligned=0x7F7FFFFF, hidden=1 -> result=0x7F800000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Check:
  - result stays stable and out_valid=1
  - in_ready=0, and in_valid pulses in that window are ignored
  - out_ready=1 -> IDLE, and in_ready=1 on the next cycle
- Reset mid-NORM (1.0-0.75 case, reset asserted at the first NORM cycle) -> next cycle out_valid=0, in_ready=1, result=0. The following transaction completes correctly.
